// File: rtl/relu_act_pipe_pkg.sv
// Shared types and helpers for the multi-lane activation pipeline.
// The activation mode travels with each beat, so its encoding lives here.
package relu_act_pkg;

  localparam int ACT_MODE_W = 2;

  typedef enum logic [ACT_MODE_W-1:0] {
    ACT_PASS  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2,
    ACT_CLAMP = 2'd3
  } act_mode_e;

  // Bits needed to hold a per-beat clip count in the range 0..lanes.
  function automatic int clip_count_width(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/relu_act_lane.sv
// One signed lane of the activation: purely combinational.
// Flags a clip whenever the activation changed the lane (leaky counts every negative lane).
module relu_act_lane
  import relu_act_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LEAK_SHIFT = 3
) (
  input  logic signed [DATA_WIDTH-1:0] x,
  input  act_mode_e                    mode,
  input  logic signed [DATA_WIDTH-1:0] clamp_max,
  output logic signed [DATA_WIDTH-1:0] y,
  output logic                         clip
);

  logic                         neg_s;
  logic                         over_s;
  logic signed [DATA_WIDTH-1:0] hi_s;

  assign neg_s  = x[DATA_WIDTH-1];
  // A negative clamp bound collapses to zero, so every lane of such a beat ends up at 0.
  assign hi_s   = clamp_max[DATA_WIDTH-1] ? {DATA_WIDTH{1'b0}} : clamp_max;
  assign over_s = (x > hi_s);

  // Activation select and clip flag for this lane.
  always_comb begin
    y    = x;
    clip = 1'b0;
    case (mode)
      ACT_PASS: begin
        y    = x;
        clip = 1'b0;
      end
      ACT_RELU: begin
        if (neg_s) begin
          y    = {DATA_WIDTH{1'b0}};
          clip = 1'b1;
        end else begin
          y    = x;
          clip = 1'b0;
        end
      end
      ACT_LEAKY: begin
        if (neg_s) begin
          y    = x >>> LEAK_SHIFT;
          clip = 1'b1;
        end else begin
          y    = x;
          clip = 1'b0;
        end
      end
      ACT_CLAMP: begin
        if (neg_s) begin
          y    = {DATA_WIDTH{1'b0}};
          clip = 1'b1;
        end else if (over_s) begin
          y    = hi_s;
          clip = 1'b1;
        end else begin
          y    = x;
          clip = 1'b0;
        end
      end
      default: begin
        y    = x;
        clip = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/relu_act_pipe.sv
// Two-stage valid/ready activation pipeline over LANES signed lanes,
// with a saturating count of lanes altered by the activation.
module relu_act_pipe
  import relu_act_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int LANES       = 4,
  parameter int LEAK_SHIFT  = 3,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data,
  input  logic [ACT_MODE_W-1:0]         in_mode,
  input  logic [DATA_WIDTH-1:0]         clamp_max,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_WIDTH-1:0]   out_data,
  output logic [COUNT_WIDTH-1:0]        clip_count,
  input  logic                          cnt_clr
);

  localparam int PW     = LANES * DATA_WIDTH;
  localparam int CLIP_W = clip_count_width(LANES);
  localparam int SUM_W  = COUNT_WIDTH + 1;

  logic                   s1_valid_r;
  logic [PW-1:0]          s1_data_r;
  act_mode_e              s1_mode_r;
  logic [DATA_WIDTH-1:0]  s1_clamp_r;

  logic                   s2_valid_r;
  logic [PW-1:0]          s2_data_r;
  logic [CLIP_W-1:0]      s2_clips_r;
  logic [COUNT_WIDTH-1:0] clip_count_r;

  logic                   s2_load_s;
  logic                   s1_load_s;
  logic [PW-1:0]          act_data_s;
  logic [LANES-1:0]       lane_clip_s;
  logic [CLIP_W-1:0]      clips_s;
  logic [SUM_W-1:0]       sum_s;
  logic [COUNT_WIDTH-1:0] count_next_s;

  // The only combinational path to in_ready is from out_ready through s2_load_s.
  assign s2_load_s  = !s2_valid_r || out_ready;
  assign s1_load_s  = !s1_valid_r || s2_load_s;
  assign in_ready   = s1_load_s;
  assign out_valid  = s2_valid_r;
  assign out_data   = s2_data_r;
  assign clip_count = clip_count_r;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    relu_act_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .LEAK_SHIFT (LEAK_SHIFT)
    ) u_lane (
      .x         (s1_data_r[i*DATA_WIDTH +: DATA_WIDTH]),
      .mode      (s1_mode_r),
      .clamp_max (s1_clamp_r),
      .y         (act_data_s[i*DATA_WIDTH +: DATA_WIDTH]),
      .clip      (lane_clip_s[i])
    );
  end

  // Population count of per-lane clip flags for the beat in stage 1.
  always_comb begin
    clips_s = {CLIP_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      clips_s = clips_s + CLIP_W'(lane_clip_s[i]);
    end
  end

  // Saturating next value of the clip counter.
  always_comb begin
    sum_s = {1'b0, clip_count_r} + SUM_W'(s2_clips_r);
    if (sum_s[COUNT_WIDTH]) begin
      count_next_s = {COUNT_WIDTH{1'b1}};
    end else begin
      count_next_s = sum_s[COUNT_WIDTH-1:0];
    end
  end

  // Stage 1: capture the beat together with its mode and clamp bound.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= {PW{1'b0}};
      s1_mode_r  <= ACT_PASS;
      s1_clamp_r <= {DATA_WIDTH{1'b0}};
    end else if (s1_load_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_data_r  <= in_data;
        s1_mode_r  <= act_mode_e'(in_mode);
        s1_clamp_r <= clamp_max;
      end
    end
  end

  // Stage 2: register the activated beat and its clip count; holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_data_r  <= {PW{1'b0}};
      s2_clips_r <= {CLIP_W{1'b0}};
    end else if (s2_load_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_data_r  <= act_data_s;
        s2_clips_r <= clips_s;
      end
    end
  end

  // Clip counter: clear wins over a same-cycle output transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      clip_count_r <= {COUNT_WIDTH{1'b0}};
    end else if (cnt_clr) begin
      clip_count_r <= {COUNT_WIDTH{1'b0}};
    end else if (s2_valid_r && out_ready) begin
      clip_count_r <= count_next_s;
    end
  end

endmodule
